// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. A start strobe in IDLE captures two WIDTH-bit
//   operands and a carry-in. The operands are then added LSB-first, one bit
//   per clock, through a single carry flip-flop. The result is presented
//   behind a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin an addition (sampled only in IDLE)
//   a, b       operands, captured at the accepting edge
//   cin        carry-in, captured at the accepting edge
//   busy       high while in ADD
//   out_valid  high while in DONE (sum/cout/ovf valid)
//   out_ready  consumer accepts the result when high with out_valid
//   sum        registered result, modulo 2^WIDTH
//   cout       unsigned carry-out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor cout)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Full-adder cell on the current LSBs
    logic             s_bit, maj;
    logic [WIDTH-1:0] sum_shift;

    assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign maj   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    // New bit enters at the MSB. After WIDTH shifts, bit 0 of the sum sits in sum[0].
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = s_bit;
        end else begin : g_wn
            assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = sum_shift;
                carry_d = maj;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this final bit
                    cout_d  = maj;
                    ovf_d   = carry_q ^ maj;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == ADD);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end
endmodule
